// File: rtl/scan_sequencer_if.sv
// ADC conversion handshake between the scan sequencer (master)
// and the converter front end (slave).
interface scan_sequencer_if;
   logic        adc_start_out;
   logic [15:0] adc_data_in;
   logic        adc_valid_in;

   modport master (
      output adc_start_out,
      input  adc_data_in,
      input  adc_valid_in
   );

   modport slave (
      input  adc_start_out,
      output adc_data_in,
      output adc_valid_in
   );
endinterface

// File: rtl/scan_sequencer.sv
// Row/column scan of a switch/read wire matrix: one ADC conversion
// per crossing, samples emitted in raster order.
module scan_sequencer #(
   parameter int SW_WIRE_CNT   = 16,
   parameter int RD_WIRE_CNT   = 16,
   parameter int SETTLE_CYCLES = 8,
   parameter int ADC_TIMEOUT   = 64
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           start_in,
   input  logic                           stop_in,
   input  logic                           continuous_in,
   scan_sequencer_if.master               adc,
   output logic [$clog2(SW_WIRE_CNT)-1:0] sw_sel_out,
   output logic                           sw_en_out,
   output logic [$clog2(RD_WIRE_CNT)-1:0] rd_sel_out,
   output logic [10:0]                    hcount_out,
   output logic [9:0]                     vcount_out,
   output logic [15:0]                    data_out,
   output logic                           data_valid_out,
   output logic                           busy_out,
   output logic                           frame_done_out,
   output logic                           error_out
);

   localparam int RW  = $clog2(SW_WIRE_CNT);
   localparam int CW  = $clog2(RD_WIRE_CNT);
   localparam int SCW = $clog2(SETTLE_CYCLES + 1);
   localparam int TCW = $clog2(ADC_TIMEOUT + 1);

   localparam logic [RW-1:0]  ROW_LAST = RW'(SW_WIRE_CNT - 1);
   localparam logic [CW-1:0]  COL_LAST = CW'(RD_WIRE_CNT - 1);
   localparam logic [SCW-1:0] SET_LOAD = SCW'(SETTLE_CYCLES - 1);
   localparam logic [TCW-1:0] TMO_LAST = TCW'(ADC_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CONVERT,
      WAIT,
      DONE
   } state_t;

   state_t         state;
   logic [SCW-1:0] settle_cnt;
   logic [TCW-1:0] tmo_cnt;

   // sw_sel_out / rd_sel_out are the row / column index registers
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state             <= IDLE;
         settle_cnt        <= '0;
         tmo_cnt           <= '0;
         sw_sel_out        <= '0;
         rd_sel_out        <= '0;
         sw_en_out         <= 1'b0;
         adc.adc_start_out <= 1'b0;
         hcount_out        <= '0;
         vcount_out        <= '0;
         data_out          <= '0;
         data_valid_out    <= 1'b0;
         busy_out          <= 1'b0;
         frame_done_out    <= 1'b0;
         error_out         <= 1'b0;
      end else begin
         adc.adc_start_out <= 1'b0;
         data_valid_out    <= 1'b0;
         frame_done_out    <= 1'b0;
         if (stop_in && state != IDLE) begin
            state     <= IDLE;
            sw_en_out <= 1'b0;
            busy_out  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start_in) begin
                     state      <= SETTLE;
                     sw_sel_out <= '0;
                     rd_sel_out <= '0;
                     settle_cnt <= SET_LOAD;
                     sw_en_out  <= 1'b1;
                     busy_out   <= 1'b1;
                     error_out  <= 1'b0;
                  end
               end
               SETTLE: begin
                  if (settle_cnt == '0) begin
                     state             <= CONVERT;
                     adc.adc_start_out <= 1'b1;
                  end else begin
                     settle_cnt <= settle_cnt - SCW'(1);
                  end
               end
               CONVERT: begin
                  tmo_cnt <= '0;
                  state   <= WAIT;
               end
               WAIT: begin
                  if (adc.adc_valid_in) begin
                     data_out       <= adc.adc_data_in;
                     hcount_out     <= 11'(rd_sel_out);
                     vcount_out     <= 10'(sw_sel_out);
                     data_valid_out <= 1'b1;
                     if (rd_sel_out != COL_LAST) begin
                        rd_sel_out        <= rd_sel_out + CW'(1);
                        adc.adc_start_out <= 1'b1;
                        state             <= CONVERT;
                     end else if (sw_sel_out != ROW_LAST) begin
                        sw_sel_out <= sw_sel_out + RW'(1);
                        rd_sel_out <= '0;
                        settle_cnt <= SET_LOAD;
                        state      <= SETTLE;
                     end else begin
                        frame_done_out <= 1'b1;
                        sw_en_out      <= 1'b0;
                        state          <= DONE;
                     end
                  end else if (tmo_cnt == TMO_LAST) begin
                     error_out <= 1'b1;
                     sw_en_out <= 1'b0;
                     busy_out  <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     tmo_cnt <= tmo_cnt + TCW'(1);
                  end
               end
               DONE: begin
                  if (continuous_in) begin
                     state      <= SETTLE;
                     sw_sel_out <= '0;
                     rd_sel_out <= '0;
                     settle_cnt <= SET_LOAD;
                     sw_en_out  <= 1'b1;
                  end else begin
                     state    <= IDLE;
                     busy_out <= 1'b0;
                  end
               end
               default: begin
                  state    <= IDLE;
                  busy_out <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: directed scans against a
// two-cycle-latency ADC model that can go silent at one crossing.
module tb_scan_sequencer;

   logic        clk = 1'b0;
   logic        rst_in = 1'b0;
   logic        start_in = 1'b0;
   logic        stop_in = 1'b0;
   logic        continuous_in = 1'b0;
   logic [3:0]  sw_sel_out;
   logic        sw_en_out;
   logic [3:0]  rd_sel_out;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
   logic [15:0] data_out;
   logic        data_valid_out;
   logic        busy_out;
   logic        frame_done_out;
   logic        error_out;

   scan_sequencer_if adc_if ();

   scan_sequencer dut (
      .clk_in         (clk),
      .rst_in         (rst_in),
      .start_in       (start_in),
      .stop_in        (stop_in),
      .continuous_in  (continuous_in),
      .adc            (adc_if.master),
      .sw_sel_out     (sw_sel_out),
      .sw_en_out      (sw_en_out),
      .rd_sel_out     (rd_sel_out),
      .hcount_out     (hcount_out),
      .vcount_out     (vcount_out),
      .data_out       (data_out),
      .data_valid_out (data_valid_out),
      .busy_out       (busy_out),
      .frame_done_out (frame_done_out),
      .error_out      (error_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  v;
      logic [10:0] h;
      logic [15:0] d;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;
   int   fd_cnt = 0;

   // ADC model: result {row,col} two cycles after adc_start_out
   logic       silent_en = 1'b0;
   logic [3:0] silent_row = '0;
   logic [3:0] silent_col = '0;
   logic       a1 = 1'b0;
   logic [15:0] d1 = '0;

   initial begin
      adc_if.adc_valid_in = 1'b0;
      adc_if.adc_data_in  = '0;
   end

   always @(posedge clk) begin
      a1 <= adc_if.adc_start_out &&
            !(silent_en && sw_sel_out == silent_row &&
              rd_sel_out == silent_col);
      d1 <= {4'b0, sw_sel_out, 4'b0, rd_sel_out};
      adc_if.adc_valid_in <= a1;
      adc_if.adc_data_in  <= d1;
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push_range(input int r0, input int c0,
                             input int r1, input int c1);
      exp_t x;
      for (int r = r0; r <= r1; r++)
         for (int c = (r == r0 ? c0 : 0);
              c <= (r == r1 ? c1 : 15); c++) begin
            x.v = 10'(r);
            x.h = 11'(c);
            x.d = {8'(r), 8'(c)};
            sb.push_back(x);
         end
   endtask

   // Monitor: every emitted sample is popped and compared
   always @(negedge clk) begin
      if (frame_done_out) fd_cnt++;
      if (data_valid_out) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got v=%0d h=%0d want none",
                     vcount_out, hcount_out);
         end else begin
            e = sb.pop_front();
            check("vcount", 32'(vcount_out), 32'(e.v));
            check("hcount", 32'(hcount_out), 32'(e.h));
            check("data", 32'(data_out), 32'(e.d));
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
   endtask

   task automatic wait_fd(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (frame_done_out) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   bit ok;
   bit en_ok;
   int n;
   int fd0;

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      check("rst_outs_zero", 32'(|{sw_sel_out, sw_en_out, rd_sel_out,
            adc_if.adc_start_out, hcount_out, vcount_out, data_out,
            data_valid_out, busy_out, frame_done_out, error_out}), 0);
      rst_in = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy", 32'(busy_out), 0);

      // full frame, settle timing on first row and row 0->1
      fd0 = fd_cnt;
      push_range(0, 0, 15, 15);
      pulse_start();
      check("start_busy", 32'(busy_out), 1);
      check("start_sw_en", 32'(sw_en_out), 1);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n++;
         if (adc_if.adc_start_out) break;
      end
      check("first_settle", 32'(n), 8);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (sw_sel_out == 4'd1) begin
            ok = 1'b1;
            break;
         end
      end
      check("row1_seen", 32'(ok), 1);
      check("row1_sw_en", 32'(sw_en_out), 1);
      n = 0;
      en_ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n++;
         if (!sw_en_out) en_ok = 1'b0;
         if (adc_if.adc_start_out) break;
      end
      check("row1_settle", 32'(n), 8);
      check("row1_sw_en_held", 32'(en_ok), 1);
      wait_fd(5000, ok);
      check("frame_done_seen", 32'(ok), 1);
      check("done_sw_en", 32'(sw_en_out), 0);
      @(negedge clk);
      check("done_idle", 32'(busy_out), 0);
      repeat (10) @(negedge clk);
      check("frame_sb_empty", 32'(sb.size()), 0);
      check("frame_fd_cnt", 32'(fd_cnt - fd0), 1);

      // ADC silent at row 2 col 5 -> timeout
      fd0 = fd_cnt;
      silent_row = 4'd2;
      silent_col = 4'd5;
      silent_en  = 1'b1;
      push_range(0, 0, 2, 4);
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (adc_if.adc_start_out && sw_sel_out == 4'd2 &&
             rd_sel_out == 4'd5) begin
            ok = 1'b1;
            break;
         end
      end
      check("silent_conv_seen", 32'(ok), 1);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n++;
         if (!busy_out) break;
      end
      check("tmo_cycles", 32'(n), 65);
      check("tmo_error", 32'(error_out), 1);
      check("tmo_busy", 32'(busy_out), 0);
      check("tmo_sw_en", 32'(sw_en_out), 0);
      check("tmo_vcount", 32'(vcount_out), 2);
      check("tmo_hcount", 32'(hcount_out), 4);
      repeat (5) @(negedge clk);
      check("tmo_sb_empty", 32'(sb.size()), 0);
      check("tmo_no_fd", 32'(fd_cnt - fd0), 0);
      check("tmo_error_sticky", 32'(error_out), 1);
      silent_en = 1'b0;
      pulse_start();
      check("restart_clr_err", 32'(error_out), 0);
      check("restart_busy", 32'(busy_out), 1);
      stop_in = 1'b1;
      @(negedge clk);
      stop_in = 1'b0;
      check("stop_settle_idle", 32'(busy_out), 0);

      // stop on the same cycle as adc_valid_in
      fd0 = fd_cnt;
      push_range(0, 0, 0, 2);
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (adc_if.adc_valid_in && sw_sel_out == 4'd0 &&
             rd_sel_out == 4'd3) begin
            ok = 1'b1;
            break;
         end
      end
      check("stop_valid_seen", 32'(ok), 1);
      stop_in = 1'b1;
      @(negedge clk);
      stop_in = 1'b0;
      check("stop_no_sample", 32'(data_valid_out), 0);
      check("stop_busy", 32'(busy_out), 0);
      check("stop_sw_en", 32'(sw_en_out), 0);
      check("stop_no_fd_now", 32'(frame_done_out), 0);
      repeat (20) @(negedge clk);
      check("stop_sb_empty", 32'(sb.size()), 0);
      check("stop_no_fd", 32'(fd_cnt - fd0), 0);

      // continuous mode over two frames, start ignored mid-frame
      fd0 = fd_cnt;
      continuous_in = 1'b1;
      push_range(0, 0, 15, 15);
      push_range(0, 0, 15, 15);
      pulse_start();
      repeat (300) @(negedge clk);
      pulse_start();
      for (int f = 0; f < 2; f++) begin
         wait_fd(5000, ok);
         check("cont_fd_seen", 32'(ok), 1);
         @(negedge clk);
         check("cont_settle_busy", 32'(busy_out), 1);
         check("cont_settle_row", 32'(sw_sel_out), 0);
         check("cont_settle_en", 32'(sw_en_out), 1);
      end
      continuous_in = 1'b0;
      stop_in = 1'b1;
      @(negedge clk);
      stop_in = 1'b0;
      check("cont_stop_busy", 32'(busy_out), 0);
      repeat (10) @(negedge clk);
      check("cont_sb_empty", 32'(sb.size()), 0);
      check("cont_fd_cnt", 32'(fd_cnt - fd0), 2);

      // asynchronous reset mid-row
      fd0 = fd_cnt;
      push_range(0, 0, 1, 3);
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("arst_row1_reached", 32'(ok), 1);
      #1;
      rst_in = 1'b0;
      #1;
      check("arst_outs_zero", 32'(|{sw_sel_out, sw_en_out, rd_sel_out,
            adc_if.adc_start_out, hcount_out, vcount_out, data_out,
            data_valid_out, busy_out, frame_done_out, error_out}), 0);
      @(negedge clk);
      rst_in = 1'b1;
      repeat (300) @(negedge clk);
      check("arst_busy", 32'(busy_out), 0);
      check("arst_sw_en", 32'(sw_en_out), 0);
      check("arst_no_fd", 32'(fd_cnt - fd0), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter SW_WIRE_CNT, default 16: number of switch (drive) wires, i.e. rows per frame.
REQ-002 SHALL have parameter RD_WIRE_CNT, default 16: number of read (sense) wires, i.e. columns per row.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8: idle cycles after a row select before the first conversion of that row.
REQ-004 SHALL have parameter ADC_TIMEOUT, default 64: maximum cycles to wait for an ADC result.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk_in  input  1  system clock, rising edge.
REQ-007 rst_in  input  1  asynchronous, active-low reset.
REQ-008 start_in  input  1  one-cycle request to begin a frame scan.
REQ-009 stop_in  input  1  abort the scan in progress.
REQ-010 continuous_in  input  1  when high, restart a new frame automatically after each completed frame.
REQ-011 adc_data_in  input  16  conversion result.
REQ-012 adc_valid_in  input  1  adc_data_in is valid this cycle.
REQ-013 sw_sel_out  output  $clog2(SW_WIRE_CNT)  selected switch wire (row).
REQ-014 sw_en_out  output  1  switch-wire drive enable.
REQ-015 rd_sel_out  output  $clog2(RD_WIRE_CNT)  selected read wire (column).
REQ-016 adc_start_out  output  1  one-cycle conversion request.
REQ-017 hcount_out  output  11  column index of the emitted sample.
REQ-018 vcount_out  output  10  row index of the emitted sample.
REQ-019 data_out  output  16  emitted sample value.
REQ-020 data_valid_out  output  1  one-cycle strobe marking an emitted sample; intended to feed buffer data_valid_in.
REQ-021 busy_out  output  1  high whenever the state is not IDLE.
REQ-022 frame_done_out  output  1  one-cycle pulse at the end of a frame.
REQ-023 error_out  output  1  sticky flag set on ADC timeout.

Function
REQ-024 The FSM SHALL implement the states IDLE, SETTLE, CONVERT, WAIT and DONE; all outputs SHALL be registered.
REQ-025 IDLE: on start_in=1, the block SHALL load row=0, col=0 and the settle counter with SETTLE_CYCLES-1, set sw_en_out=1 and go to SETTLE; error_out SHALL clear on this start.
REQ-026 SETTLE: the counter SHALL decrement each cycle; at 0 the FSM SHALL go to CONVERT, giving exactly SETTLE_CYCLES cycles in SETTLE.
REQ-027 CONVERT: the block SHALL hold rd_sel_out=col, assert adc_start_out for exactly this one cycle, clear the timeout counter, and go to WAIT.
REQ-028 WAIT: on adc_valid_in=1, the block SHALL register data_out=adc_data_in, hcount_out=col and vcount_out=row, and set data_valid_out=1 on the following cycle for one cycle.
REQ-029 After a capture in WAIT: if col<RD_WIRE_CNT-1, col SHALL increment and the FSM SHALL go to CONVERT; if col is last and row<SW_WIRE_CNT-1, row SHALL increment, col SHALL reset to 0, the settle counter SHALL reload and the FSM SHALL go to SETTLE; if both are last, the FSM SHALL go to DONE.
REQ-030 sw_sel_out SHALL equal row and SHALL change only on the transition into SETTLE.
REQ-031 DONE: frame_done_out SHALL be 1 for one cycle and sw_en_out SHALL be 0; next state SHALL be SETTLE with row=0, col=0 if continuous_in=1, else IDLE.
REQ-032 Timeout: if WAIT lasts ADC_TIMEOUT cycles without adc_valid_in, error_out SHALL set, sw_en_out SHALL clear and the FSM SHALL go to IDLE, emitting no sample and no frame_done_out.
REQ-033 stop_in=1 in any non-IDLE state SHALL force IDLE on the next edge with sw_en_out=0 and no frame_done_out; stop_in SHALL take priority over every other transition, including a same-cycle adc_valid_in.
REQ-034 start_in SHALL be ignored while busy_out=1; adc_valid_in SHALL be ignored outside WAIT.
REQ-035 In all states other than the capture cycle, data_valid_out SHALL be 0 and hcount_out, vcount_out and data_out SHALL hold their last values.

Reset
REQ-036 While rst_in=0, the state SHALL be IDLE and every output, counter and index SHALL be 0, including error_out.
REQ-037 Reset asserted mid-frame SHALL abort immediately; after release, no sample SHALL be emitted until a new start_in.

Verification
REQ-038 Default parameters, ADC model returning {row[7:0],col[7:0]} 2 cycles after adc_start_out, single start_in -> 256 data_valid_out pulses in raster order with hcount 0..15 and vcount 0..15, data_out matching, and exactly 1 frame_done_out.
REQ-039 Row 0 to row 1 transition -> sw_sel_out changes, then exactly 8 cycles elapse before the next adc_start_out, and sw_en_out stays 1 throughout.
REQ-040 ADC model silent at row 2, col 5 -> after 64 WAIT cycles, error_out=1, busy_out=0, last vcount/hcount = 2/4; a new start_in clears error_out.
REQ-041 stop_in asserted on the same cycle as adc_valid_in -> no data_valid_out, IDLE next cycle, sw_en_out=0, no frame_done_out.
REQ-042 continuous_in=1 over 2 frames -> 2 frame_done_out pulses, each followed next cycle by SETTLE with sw_sel_out=0; start_in pulsed mid-frame has no effect.
REQ-043 rst_in pulled low mid-row -> all outputs 0 asynchronously (before the next clock edge), state IDLE after release.
